// File: rtl/control_unit.sv
// control_unit
// Hardwired control sequencer for a simple single-bus CPU datapath. It steps
// through a fetch (T0..T2) and an opcode-specific execute phase (T3..T7),
// with Moore strobes decoded from the current step and the opcode.
//
// Ports
//   Clock      : system clock, rising-edge active
//   Resetn     : synchronous active-low reset
//   IR[31:0]   : instruction register (opcode = IR[31:27])
//   CON_FF     : branch condition from the datapath (used in br T6)
//   Stop       : halt request, honoured only at instruction boundaries
//   Mem_ready  : memory handshake; completes a Read or Write this cycle
//   PCout..CONin : datapath bus / load / select strobes
//   ALU_op[4:0]: ALU operation code
//   Clear      : high in RESET, clears the datapath PC
//   Run        : high in every state except RESET and HALT
module control_unit (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        Stop,
  input  logic        Mem_ready,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        Write,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIin,
  output logic        LOin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic        CONin,
  output logic [4:0]  ALU_op,
  output logic        Clear,
  output logic        Run
);

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_MUL  = 5'b01000;
  localparam logic [4:0] OP_DIV  = 5'b01001;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t     state, next_state;
  logic [4:0] op_reg;
  logic [4:0] cur_op;
  logic       is_alu, is_muldiv, is_ldi, is_ld, is_st, is_br, is_halt;
  state_t     boundary_state;
  logic       unused_ir_bits;

  // Only the opcode field matters to the sequencer; register fields are
  // decoded by the datapath through Gra/Grb/Grc.
  assign unused_ir_bits = ^IR[26:0];

  // State register.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state <= S_RESET;
    end else begin
      state <= next_state;
    end
  end

  // The opcode is read straight from IR during T3 and frozen at the end of
  // T3, so later IR changes cannot redirect an instruction in flight.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      op_reg <= 5'b0;
    end else if (state == S_T3) begin
      op_reg <= IR[31:27];
    end
  end

  assign cur_op = (state == S_T3) ? IR[31:27] : op_reg;

  // Opcode classes; anything not listed falls through to nop behaviour.
  always_comb begin
    is_alu    = (cur_op == OP_ADD) || (cur_op == OP_SUB) ||
                (cur_op == OP_AND) || (cur_op == OP_OR);
    is_muldiv = (cur_op == OP_MUL) || (cur_op == OP_DIV);
    is_ldi    = (cur_op == OP_LDI);
    is_ld     = (cur_op == OP_LD);
    is_st     = (cur_op == OP_ST);
    is_br     = (cur_op == OP_BR);
    is_halt   = (cur_op == OP_HALT);
  end

  // Every end-of-instruction goes through here so Stop is only seen at
  // instruction boundaries.
  assign boundary_state = Stop ? S_HALT : S_T0;

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_RESET: next_state = S_T0;
      S_T0:    next_state = S_T1;
      S_T1:    next_state = Mem_ready ? S_T2 : S_T1;
      S_T2:    next_state = S_T3;
      S_T3: begin
        if (is_halt) begin
          next_state = S_HALT;
        end else if (is_alu || is_muldiv || is_ldi || is_ld || is_st || is_br) begin
          next_state = S_T4;
        end else begin
          next_state = boundary_state;
        end
      end
      S_T4:    next_state = S_T5;
      S_T5:    next_state = (is_alu || is_ldi) ? boundary_state : S_T6;
      S_T6: begin
        if (is_ld) begin
          next_state = Mem_ready ? S_T7 : S_T6;
        end else if (is_st) begin
          next_state = S_T7;
        end else begin
          next_state = boundary_state;
        end
      end
      S_T7: begin
        if (is_st) begin
          next_state = Mem_ready ? boundary_state : S_T7;
        end else begin
          next_state = boundary_state;
        end
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_RESET;
    endcase
  end

  // Moore output decode.
  always_comb begin
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
    MDRin = 1'b0; MDRout = 1'b0; Read = 1'b0; Write = 1'b0;
    IRin = 1'b0; Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0;
    HIin = 1'b0; LOin = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    BAout = 1'b0; Cout = 1'b0; CONin = 1'b0;
    ALU_op = 5'b0;
    Clear = (state == S_RESET);
    Run = (state != S_RESET) && (state != S_HALT);
    case (state)
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: begin
        if (is_alu) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (is_muldiv) begin
          Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (is_ldi || is_ld || is_st) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else if (is_br) begin
          Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
        end
      end
      S_T4: begin
        if (is_alu) begin
          Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_op = cur_op;
        end else if (is_muldiv) begin
          Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_op = cur_op;
        end else if (is_ldi || is_ld || is_st) begin
          Cout = 1'b1; Zin = 1'b1; ALU_op = OP_ADD;
        end else if (is_br) begin
          PCout = 1'b1; Yin = 1'b1;
        end
      end
      S_T5: begin
        if (is_alu || is_ldi) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (is_muldiv) begin
          Zlowout = 1'b1; LOin = 1'b1;
        end else if (is_ld || is_st) begin
          Zlowout = 1'b1; MARin = 1'b1;
        end else if (is_br) begin
          Cout = 1'b1; Zin = 1'b1; ALU_op = OP_ADD;
        end
      end
      S_T6: begin
        if (is_muldiv) begin
          Zhighout = 1'b1; HIin = 1'b1;
        end else if (is_ld) begin
          Read = 1'b1; MDRin = 1'b1;
        end else if (is_st) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
        end else if (is_br) begin
          Zlowout = 1'b1; PCin = CON_FF;
        end
      end
      S_T7: begin
        if (is_ld) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (is_st) begin
          Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit
// Self-checking bench for control_unit. Each table record describes one
// instruction (IR, CON_FF, memory wait cycles, last execute step, optional
// Stop / mid-instruction reset). Expected output vectors are pushed to a
// scoreboard queue as the stimulus for each edge is driven and popped when
// the DUT output is sampled on the following falling edge.
module tb_control_unit;

  logic        Clock;
  logic        Resetn;
  logic [31:0] IR;
  logic        CON_FF, Stop, Mem_ready;
  logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write;
  logic        IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin;
  logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin;
  logic [4:0]  ALU_op;
  logic        Clear, Run;

  control_unit dut (
    .Clock(Clock), .Resetn(Resetn), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
    .Mem_ready(Mem_ready),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
    .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .Write(Write),
    .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .HIin(HIin), .LOin(LOin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .BAout(BAout), .Cout(Cout), .CONin(CONin),
    .ALU_op(ALU_op), .Clear(Clear), .Run(Run)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Output vector bit map (bits 4:0 hold ALU_op).
  localparam logic [29:0] B_PCOUT = 30'd1 << 29, B_PCIN = 30'd1 << 28,
    B_INCPC = 30'd1 << 27, B_MARIN = 30'd1 << 26, B_MDRIN = 30'd1 << 25,
    B_MDROUT = 30'd1 << 24, B_READ = 30'd1 << 23, B_WRITE = 30'd1 << 22,
    B_IRIN = 30'd1 << 21, B_YIN = 30'd1 << 20, B_ZIN = 30'd1 << 19,
    B_ZLOW = 30'd1 << 18, B_ZHIGH = 30'd1 << 17, B_HIIN = 30'd1 << 16,
    B_LOIN = 30'd1 << 15, B_GRA = 30'd1 << 14, B_GRB = 30'd1 << 13,
    B_GRC = 30'd1 << 12, B_RIN = 30'd1 << 11, B_ROUT = 30'd1 << 10,
    B_BAOUT = 30'd1 << 9, B_COUT = 30'd1 << 8, B_CONIN = 30'd1 << 7,
    B_CLEAR = 30'd1 << 6, B_RUN = 30'd1 << 5;

  localparam int ST_RESET = 8;
  localparam int ST_HALT  = 9;

  logic [29:0] dut_vec;
  assign dut_vec = {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write,
                    IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin,
                    Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin,
                    Clear, Run, ALU_op};

  typedef struct {
    logic [29:0] vec;
    string       name;
  } sb_entry_t;

  typedef struct {
    string       name;
    logic [31:0] ir;
    logic        con;
    int          fetch_wait;
    int          wait_step;
    int          data_wait;
    int          last_step;
    int          stop_at;
    int          reset_at;
  } instr_t;

  sb_entry_t sb_q[$];
  int errors = 0;
  int checks = 0;

  // Expected outputs for a given step (0..7 = T0..T7, 8 RESET, 9 HALT).
  function automatic logic [29:0] model_vec(int st, logic [4:0] op, logic con);
    logic [29:0] v;
    logic alu, md, imm, ld, st_op, br;
    alu   = (op == 5'd3) || (op == 5'd4) || (op == 5'd5) || (op == 5'd6);
    md    = (op == 5'd8) || (op == 5'd9);
    imm   = (op == 5'd1);
    ld    = (op == 5'd0);
    st_op = (op == 5'd2);
    br    = (op == 5'd18);
    v = '0;
    if (st == ST_RESET) begin
      v = B_CLEAR;
    end else if (st == ST_HALT) begin
      v = '0;
    end else begin
      v = B_RUN;
      case (st)
        0: v |= B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
        1: v |= B_ZLOW | B_PCIN | B_READ | B_MDRIN;
        2: v |= B_MDROUT | B_IRIN;
        3: begin
          if (alu) v |= B_GRB | B_ROUT | B_YIN;
          if (md) v |= B_GRA | B_ROUT | B_YIN;
          if (imm || ld || st_op) v |= B_GRB | B_BAOUT | B_YIN;
          if (br) v |= B_GRA | B_ROUT | B_CONIN;
        end
        4: begin
          if (alu) v |= B_GRC | B_ROUT | B_ZIN | {25'd0, op};
          if (md) v |= B_GRB | B_ROUT | B_ZIN | {25'd0, op};
          if (imm || ld || st_op) v |= B_COUT | B_ZIN | 30'd3;
          if (br) v |= B_PCOUT | B_YIN;
        end
        5: begin
          if (alu || imm) v |= B_ZLOW | B_GRA | B_RIN;
          if (md) v |= B_ZLOW | B_LOIN;
          if (ld || st_op) v |= B_ZLOW | B_MARIN;
          if (br) v |= B_COUT | B_ZIN | 30'd3;
        end
        6: begin
          if (md) v |= B_ZHIGH | B_HIIN;
          if (ld) v |= B_READ | B_MDRIN;
          if (st_op) v |= B_GRA | B_ROUT | B_MDRIN;
          if (br) v |= B_ZLOW | (con ? B_PCIN : 30'd0);
        end
        7: begin
          if (ld) v |= B_MDROUT | B_GRA | B_RIN;
          if (st_op) v |= B_WRITE;
        end
        default: ;
      endcase
    end
    return v;
  endfunction

  task automatic checkOutput();
    sb_entry_t e;
    if (sb_q.size() == 0) begin
      errors++;
      checks++;
      $display("[TB] FAIL scoreboard_empty: no expected entry for output %h", dut_vec);
      return;
    end
    e = sb_q.pop_front();
    checks++;
    if (dut_vec !== e.vec) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", e.name, dut_vec, e.vec);
    end
  endtask

  // Drive inputs for the next rising edge, record what the DUT should show
  // after it, then sample on the falling edge.
  task automatic applyStimulus(input logic rn, input logic mr, input logic stp,
                               input logic [29:0] exp_next, input string nm);
    sb_entry_t e;
    Resetn = rn;
    Mem_ready = mr;
    Stop = stp;
    e.vec = exp_next;
    e.name = nm;
    sb_q.push_back(e);
    @(posedge Clock);
    @(negedge Clock);
    checkOutput();
  endtask

  task automatic reset_pulse(input string nm);
    applyStimulus(1'b0, 1'b1, 1'b0, model_vec(ST_RESET, 5'd0, 1'b0), {nm, "_reset"});
    applyStimulus(1'b1, 1'b1, 1'b0, model_vec(0, 5'd0, 1'b0), {nm, "_t0"});
  endtask

  // Runs one instruction starting with the DUT in T0; leaves it in T0.
  task automatic exec_instr(input instr_t e);
    int cur;
    int waits;
    logic stp;
    logic [4:0] op;
    bit done;
    op = e.ir[31:27];
    IR = e.ir;
    CON_FF = e.con;
    cur = 0;
    done = 0;
    while (!done) begin
      // IR is scrambled once the opcode should be frozen.
      if (cur >= 4) IR = ~e.ir;
      stp = (e.stop_at != 0) && (cur >= e.stop_at);
      if (e.reset_at != 0 && cur == e.reset_at) begin
        reset_pulse({e.name, "_midrst"});
        done = 1;
      end else begin
        waits = (cur == 1) ? e.fetch_wait : ((cur == e.wait_step) ? e.data_wait : 0);
        for (int i = 0; i < waits; i++)
          applyStimulus(1'b1, 1'b0, stp, model_vec(cur, op, e.con),
                        $sformatf("%s_wait_t%0d", e.name, cur));
        if (cur == e.last_step) begin
          if (stp || op == 5'b11011) begin
            applyStimulus(1'b1, 1'b1, stp, model_vec(ST_HALT, op, e.con), {e.name, "_halt"});
            applyStimulus(1'b1, 1'b1, 1'b0, model_vec(ST_HALT, op, e.con), {e.name, "_halt_hold"});
            reset_pulse(e.name);
          end else begin
            applyStimulus(1'b1, 1'b1, stp, model_vec(0, op, e.con), {e.name, "_next_t0"});
          end
          done = 1;
        end else begin
          applyStimulus(1'b1, 1'b1, stp, model_vec(cur + 1, op, e.con),
                        $sformatf("%s_t%0d", e.name, cur + 1));
          cur++;
        end
      end
    end
  endtask

  instr_t vectors[$];

  function automatic instr_t mk(string nm, logic [31:0] ir, logic con, int fw,
                                int ws, int dw, int last, int stop_at, int rst_at);
    instr_t t;
    t.name = nm; t.ir = ir; t.con = con; t.fetch_wait = fw;
    t.wait_step = ws; t.data_wait = dw; t.last_step = last;
    t.stop_at = stop_at; t.reset_at = rst_at;
    return t;
  endfunction

  initial begin
    Resetn = 1'b0;
    IR = 32'h0;
    CON_FF = 1'b0;
    Stop = 1'b0;
    Mem_ready = 1'b1;

    vectors.push_back(mk("sub",      32'h20918000, 1'b0, 0, 0, 0, 5, 0, 0));
    vectors.push_back(mk("mul",      32'h43380000, 1'b0, 0, 0, 0, 6, 0, 0));
    vectors.push_back(mk("ld_wait",  32'h00800000, 1'b0, 0, 6, 3, 7, 0, 0));
    vectors.push_back(mk("br_nt",    32'h90800000, 1'b0, 0, 0, 0, 6, 0, 0));
    vectors.push_back(mk("br_t",     32'h90800000, 1'b1, 0, 0, 0, 6, 0, 0));
    vectors.push_back(mk("add_fw",   32'h19918000, 1'b0, 2, 0, 0, 5, 0, 0));
    vectors.push_back(mk("and",      32'h28918000, 1'b0, 0, 0, 0, 5, 0, 0));
    vectors.push_back(mk("or",       32'h30918000, 1'b0, 0, 0, 0, 5, 0, 0));
    vectors.push_back(mk("div",      32'h48900000, 1'b0, 0, 0, 0, 6, 0, 0));
    vectors.push_back(mk("ldi",      32'h08800000, 1'b0, 0, 0, 0, 5, 0, 0));
    vectors.push_back(mk("st_wait",  32'h10800000, 1'b0, 1, 7, 2, 7, 0, 0));
    vectors.push_back(mk("nop",      32'hD0000000, 1'b0, 0, 0, 0, 3, 0, 0));
    vectors.push_back(mk("undef",    32'h78000000, 1'b0, 0, 0, 0, 3, 0, 0));
    vectors.push_back(mk("st_rst",   32'h10800000, 1'b0, 0, 7, 0, 7, 0, 4));
    vectors.push_back(mk("add_stop", 32'h19918000, 1'b0, 0, 0, 0, 5, 4, 0));
    vectors.push_back(mk("halt",     32'hD8000000, 1'b0, 0, 0, 0, 3, 0, 0));
    vectors.push_back(mk("sub_end",  32'h20918000, 1'b0, 0, 0, 0, 5, 0, 0));

    @(negedge Clock);
    applyStimulus(1'b0, 1'b1, 1'b0, model_vec(ST_RESET, 5'd0, 1'b0), "reset_hold");
    applyStimulus(1'b1, 1'b1, 1'b0, model_vec(0, 5'd0, 1'b0), "reset_release_t0");

    foreach (vectors[k]) exec_instr(vectors[k]);

    // Reset asserted during fetch also returns to RESET.
    IR = 32'h20918000;
    applyStimulus(1'b1, 1'b0, 1'b0, model_vec(1, 5'd4, 1'b0), "fetch_t1");
    reset_pulse("fetch_rst");

    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
    end
    checks++;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] timeout");
  end

endmodule
